axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Per-slave read-channel scheduler for the AXI interconnect.
- Arbitrates AR requests from masters M0 and M1 onto one slave port using round-robin.
- Locks the slave's R channel to the winning master until the RLAST beat completes.
- Drives the select for the external AR/R payload muxes, the master-ID prefix for the slave-side ID, and checks each burst's beat count against ARLEN.

Parameters:
LEN_BITS, 4, width of ARLEN (matches AXI_LEN_BITS)

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset
ARVALID_M0  in  1  M0 address request
ARLEN_M0  in  LEN_BITS  M0 burst length minus 1
ARREADY_M0  out  1  AR accept to M0
ARVALID_M1  in  1  M1 address request
ARLEN_M1  in  LEN_BITS  M1 burst length minus 1
ARREADY_M1  out  1  AR accept to M1
ARVALID_S  out  1  address valid to slave
ARREADY_S  in  1  slave address accept
RVALID_S  in  1  slave read data valid
RLAST_S  in  1  slave last beat
RREADY_S  out  1  read ready to slave
RVALID_M0  out  1  read valid to M0
RREADY_M0  in  1  M0 read ready
RVALID_M1  out  1  read valid to M1
RREADY_M1  in  1  M1 read ready
grant_sel  out  1  owning master (0=M0, 1=M1); AR/R mux select and slave ID prefix
busy  out  1  high when state != IDLE
len_err  out  1  sticky burst-length mismatch flag
err_clr  in  1  clears len_err

Behaviour:
- Clocking and reset: single clock ACLK. Reset ARESETn is synchronous, active-low. All state updates on ACLK rising edge.
- Reset values:
  - state=IDLE, grant_sel=0, last_grant=1 (M0 wins first tie), beat_cnt=0, len_q=0, len_err=0.
  - All ready/valid outputs 0, busy=0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - No handshakes are accepted.
  - Only ARVALID_M0 set -> grant_sel<=0. Only ARVALID_M1 set -> grant_sel<=1.
  - Both set -> grant_sel<=~last_grant.
  - Any request -> next state ADDR (1-cycle arbitration latency). No request -> stay.
- ADDR:
  - ARVALID_S = ARVALID of the granted master. ARREADY of the granted master = ARREADY_S. The other master's ARREADY = 0.
  - On the handshake (granted ARVALID & ARREADY_S):
    - len_q<=granted ARLEN, beat_cnt<=0, last_grant<=grant_sel.
    - Next state DATA.
  - Granted ARVALID deasserts before the handshake (protocol violation) -> return to IDLE, last_grant unchanged.
- DATA:
  - RVALID of the granted master = RVALID_S. RREADY_S = RREADY of the granted master.
  - Non-granted master: RVALID=0. All ARREADY=0.
  - Beat handshake = RVALID_S & RREADY_S.
    - Non-last beat: beat_cnt+1, saturating at 2^LEN_BITS-1.
    - Last beat (RLAST_S set): next state IDLE.
  - Length checks (set len_err):
    - A handshake with RLAST_S=1 and beat_cnt!=len_q.
    - A handshake with RLAST_S=0 and beat_cnt==len_q.
  - The burst terminates only on RLAST_S. The R lock holds regardless of len_err.
- Back-to-back bursts: a minimum one-cycle IDLE bubble between the RLAST handshake and the next ADDR.
- grant_sel holds its value in IDLE until the next arbitration. It is stable throughout ADDR and DATA.
- len_err:
  - Sticky. Cleared by err_clr.
  - err_clr in the same cycle as a new error -> len_err stays 1 (set wins).
- Reset mid-burst: returns to IDLE at the next edge. Outputs drop in that cycle. The outstanding burst is abandoned (the slave is reset by the same signal).
- Combinational paths:
  - ARREADY_Mx depends on ARREADY_S.
  - RVALID_Mx and RREADY_S depend on RVALID_S and RREADY_Mx.
  - No path from AR inputs to R outputs.

Test Plan:
- Single M0 burst:
  - Stimulus: after reset, ARVALID_M0=1, ARLEN_M0=3, ARREADY_S=1; 4 beats, RLAST on beat 4.
  - Required: grant_sel=0; ARVALID_S rises 1 cycle after the request; RVALID_M0 follows RVALID_S; RVALID_M1=0; busy falls the cycle after the RLAST handshake; len_err=0.
- Round-robin:
  - Stimulus: ARVALID_M0 and ARVALID_M1 held high continuously, ARLEN=0 each, slave always ready.
  - Required: grants alternate M0, M1, M0, M1, with one IDLE cycle between bursts.
- R lock:
  - Stimulus: during M1's DATA phase, M0 asserts ARVALID_M0.
  - Required: ARREADY_M0 stays 0 and ARVALID_S stays 0 until M1's RLAST handshake completes; M0 is granted next.
- Backpressure:
  - Stimulus: RREADY_M0 toggles 1,0,1,0 while RVALID_S=1, ARLEN=1.
  - Required: RREADY_S mirrors RREADY_M0; beat_cnt advances only on handshake cycles; completion after 2 handshakes.
- Length error:
  - Stimulus: ARLEN=3, slave asserts RLAST on beat 2.
  - Required: len_err=1 after that edge; FSM returns to IDLE. Then assert err_clr with no error -> len_err=0. Assert err_clr in the same cycle as a new error -> len_err stays 1.
- Reset mid-burst and withdrawal:
  - Stimulus: ARESETn=0 for 1 cycle during DATA.
  - Required: next cycle all outputs 0, busy=0, grant_sel=0.
  - Stimulus: ARVALID deasserted in ADDR.
  - Required: return to IDLE with last_grant unchanged.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// axi_read_arbiter
//
// Read-channel scheduler for one slave port of the AXI interconnect. Two
// masters (M0, M1) compete for the slave's AR channel under round-robin. The
// winner keeps the slave's R channel until its RLAST beat is accepted. Each
// burst's beat count is checked against the ARLEN captured at the AR handshake.
//
// The block only moves handshakes. Address and data payloads pass through
// external muxes that are steered by grant_sel. The same signal supplies the
// master-ID prefix for the slave-side ID.
//
// Ports
//   ACLK, ARESETn          clock, synchronous active-low reset
//   ARVALID_Mx, ARLEN_Mx   address request and burst length-1 from master x
//   ARREADY_Mx             AR accept back to master x
//   ARVALID_S, ARREADY_S   AR handshake toward the slave
//   RVALID_S, RLAST_S      read data valid / last beat from the slave
//   RREADY_S               read ready toward the slave
//   RVALID_Mx, RREADY_Mx   R handshake toward master x
//   grant_sel              owning master (0=M0, 1=M1)
//   busy                   high while a grant is in progress (state != IDLE)
//   len_err, err_clr       sticky burst-length mismatch flag and its clear
// -----------------------------------------------------------------------------
module axi_read_arbiter #(
    parameter int LEN_BITS = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic                ARVALID_M0,
    input  logic [LEN_BITS-1:0] ARLEN_M0,
    output logic                ARREADY_M0,

    input  logic                ARVALID_M1,
    input  logic [LEN_BITS-1:0] ARLEN_M1,
    output logic                ARREADY_M1,

    output logic                ARVALID_S,
    input  logic                ARREADY_S,

    input  logic                RVALID_S,
    input  logic                RLAST_S,
    output logic                RREADY_S,

    output logic                RVALID_M0,
    input  logic                RREADY_M0,
    output logic                RVALID_M1,
    input  logic                RREADY_M1,

    output logic                grant_sel,
    output logic                busy,
    output logic                len_err,
    input  logic                err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [LEN_BITS-1:0] BEAT_MAX = {LEN_BITS{1'b1}};

    state_t              r_state;
    logic                r_grant;
    logic                r_last_grant;
    logic [LEN_BITS-1:0] r_beat_cnt;
    logic [LEN_BITS-1:0] r_len_q;
    logic                r_len_err;

    logic                w_arvalid_g;
    logic [LEN_BITS-1:0] w_arlen_g;
    logic                w_rready_g;
    logic                w_in_addr;
    logic                w_in_data;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_len_mismatch;
    logic [1:0]          w_arready_m;
    logic [1:0]          w_rvalid_m;

    // Signals of whichever master currently owns the port.
    assign w_arvalid_g = r_grant ? ARVALID_M1 : ARVALID_M0;
    assign w_arlen_g   = r_grant ? ARLEN_M1   : ARLEN_M0;
    assign w_rready_g  = r_grant ? RREADY_M1  : RREADY_M0;

    assign w_in_addr = (r_state == ST_ADDR);
    assign w_in_data = (r_state == ST_DATA);

    assign w_ar_hs = w_in_addr & w_arvalid_g & ARREADY_S;
    assign w_r_hs  = w_in_data & RVALID_S & w_rready_g;

    // A last beat must arrive exactly at beat len_q. A non-last beat at
    // beat len_q means the slave overran the requested length.
    assign w_len_mismatch = w_r_hs & (RLAST_S ? (r_beat_cnt != r_len_q)
                                              : (r_beat_cnt == r_len_q));

    // Per-master handshake fan-out. Only the granted master sees the slave.
    // The AR and R fan-outs are gated by different states. This keeps the AR
    // inputs from ever reaching the R outputs.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign w_arready_m[gi] = w_in_addr & (r_grant == 1'(gi)) & ARREADY_S;
        assign w_rvalid_m[gi]  = w_in_data & (r_grant == 1'(gi)) & RVALID_S;
    end

    assign ARREADY_M0 = w_arready_m[0];
    assign ARREADY_M1 = w_arready_m[1];
    assign RVALID_M0  = w_rvalid_m[0];
    assign RVALID_M1  = w_rvalid_m[1];
    assign ARVALID_S  = w_in_addr & w_arvalid_g;
    assign RREADY_S   = w_in_data & w_rready_g;

    assign grant_sel = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign len_err   = r_len_err;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;   // M0 wins the first tie
            r_beat_cnt   <= '0;
            r_len_q      <= '0;
            r_len_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Arbitration takes one cycle. The grant is registered
                    // here and ARVALID_S is raised in ADDR.
                    if (ARVALID_M0 && ARVALID_M1) begin
                        r_grant <= ~r_last_grant;
                        r_state <= ST_ADDR;
                    end else if (ARVALID_M0) begin
                        r_grant <= 1'b0;
                        r_state <= ST_ADDR;
                    end else if (ARVALID_M1) begin
                        r_grant <= 1'b1;
                        r_state <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (!w_arvalid_g) begin
                        // The request was withdrawn before it was accepted.
                        // Fairness history is left alone.
                        r_state <= ST_IDLE;
                    end else if (ARREADY_S) begin
                        r_len_q      <= w_arlen_g;
                        r_beat_cnt   <= '0;
                        r_last_grant <= r_grant;
                        r_state      <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    // Only RLAST ends the burst. A length error is flagged
                    // but the R lock is kept until the slave finishes.
                    if (w_r_hs) begin
                        if (RLAST_S) begin
                            r_state <= ST_IDLE;
                        end else if (r_beat_cnt != BEAT_MAX) begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase

            // Setting has priority over clearing, so an error in the
            // clearing cycle is not lost.
            if (w_len_mismatch) begin
                r_len_err <= 1'b1;
            end else if (err_clr) begin
                r_len_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;

    logic       ACLK;
    logic       ARESETn;
    logic       ARVALID_M0, ARVALID_M1;
    logic [3:0] ARLEN_M0, ARLEN_M1;
    logic       ARREADY_M0, ARREADY_M1;
    logic       ARVALID_S, ARREADY_S;
    logic       RVALID_S, RLAST_S, RREADY_S;
    logic       RVALID_M0, RREADY_M0, RVALID_M1, RREADY_M1;
    logic       grant_sel, busy, len_err, err_clr;

    axi_read_arbiter #(.LEN_BITS(4)) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .ARVALID_M0 (ARVALID_M0),
        .ARLEN_M0   (ARLEN_M0),
        .ARREADY_M0 (ARREADY_M0),
        .ARVALID_M1 (ARVALID_M1),
        .ARLEN_M1   (ARLEN_M1),
        .ARREADY_M1 (ARREADY_M1),
        .ARVALID_S  (ARVALID_S),
        .ARREADY_S  (ARREADY_S),
        .RVALID_S   (RVALID_S),
        .RLAST_S    (RLAST_S),
        .RREADY_S   (RREADY_S),
        .RVALID_M0  (RVALID_M0),
        .RREADY_M0  (RREADY_M0),
        .RVALID_M1  (RVALID_M1),
        .RREADY_M1  (RREADY_M1),
        .grant_sel  (grant_sel),
        .busy       (busy),
        .len_err    (len_err),
        .err_clr    (err_clr)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // One cycle of stimulus and its required outputs.
    // av  = {ARVALID_M0, ARVALID_M1}
    // ctl = {ARREADY_S, RVALID_S, RLAST_S, RREADY_M0, RREADY_M1, err_clr}
    // exp = {ARVALID_S, ARREADY_M0, ARREADY_M1, RVALID_M0, RVALID_M1,
    //        RREADY_S, busy, grant_sel, len_err}
    typedef struct packed {
        logic [1:0] av;
        logic [3:0] l0;
        logic [3:0] l1;
        logic [5:0] ctl;
        logic [8:0] exp;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard of expected grant winners, in AR handshake order.
    logic exp_grant_q[$];

    function automatic vec_t V(input logic [1:0] av, input logic [3:0] l0,
                               input logic [3:0] l1, input logic [5:0] ctl,
                               input logic [8:0] exp);
        vec_t v;
        v.av = av; v.l0 = l0; v.l1 = l1; v.ctl = ctl; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive(input vec_t v);
        {ARVALID_M0, ARVALID_M1} = v.av;
        ARLEN_M0 = v.l0;
        ARLEN_M1 = v.l1;
        {ARREADY_S, RVALID_S, RLAST_S, RREADY_M0, RREADY_M1, err_clr} = v.ctl;
    endtask

    // On every AR handshake, pop the expected winner and compare it.
    task automatic sb_sample();
        logic g;
        if (ARVALID_S && ARREADY_S) begin
            if (exp_grant_q.size() == 0) begin
                chk("sb_unexpected_ar", 32'(grant_sel) + 32'd1, 32'd0);
            end else begin
                g = exp_grant_q.pop_front();
                chk("sb_grant", 32'(grant_sel), 32'(g));
                $display("AR handshake: grant_sel=%0d expected=%0d", grant_sel, g);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic [8:0] act;
        drive(v);
        #1;
        sb_sample();
        act = {ARVALID_S, ARREADY_M0, ARREADY_M1, RVALID_M0, RVALID_M1,
               RREADY_S, busy, grant_sel, len_err};
        chk(name, 32'(act), 32'(v.exp));
        step();
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        drive(V(2'b00, 4'd0, 4'd0, 6'b000000, 9'b0));
        step();
        step();
        ARESETn = 1'b1;
        run_vec(V(2'b00, 4'd0, 4'd0, 6'b000000, 9'b000000000), "reset_state");
    endtask

    vec_t tbl[7];

    initial begin
        ARESETn = 1'b0;
        drive(V(2'b00, 4'd0, 4'd0, 6'b000000, 9'b0));

        // ---- Single M0 burst, ARLEN=3 (table driven) ----
        do_reset();
        tbl[0] = V(2'b10, 4'd3, 4'd0, 6'b100000, 9'b000000000);
        tbl[1] = V(2'b10, 4'd3, 4'd0, 6'b100000, 9'b110000100);
        tbl[2] = V(2'b00, 4'd3, 4'd0, 6'b110100, 9'b000101100);
        tbl[3] = V(2'b00, 4'd3, 4'd0, 6'b110100, 9'b000101100);
        tbl[4] = V(2'b00, 4'd3, 4'd0, 6'b110100, 9'b000101100);
        tbl[5] = V(2'b00, 4'd3, 4'd0, 6'b111100, 9'b000101100);
        tbl[6] = V(2'b00, 4'd0, 4'd0, 6'b000000, 9'b000000000);
        exp_grant_q.push_back(1'b0);
        for (int k = 0; k < 7; k++) run_vec(tbl[k], $sformatf("m0_burst[%0d]", k));

        // ---- Round-robin with both masters always requesting ----
        do_reset();
        exp_grant_q.push_back(1'b0);
        exp_grant_q.push_back(1'b1);
        exp_grant_q.push_back(1'b0);
        exp_grant_q.push_back(1'b1);
        begin
            int last_hs;
            last_hs = -1;
            drive(V(2'b11, 4'd0, 4'd0, 6'b111110, 9'b0));
            for (int c = 0; c < 40 && exp_grant_q.size() > 0; c++) begin
                #1;
                if (ARVALID_S && ARREADY_S) begin
                    if (last_hs >= 0) chk("rr_gap", 32'(c - last_hs), 32'd3);
                    last_hs = c;
                end
                sb_sample();
                step();
            end
            chk("rr_all_granted", 32'(exp_grant_q.size()), 32'd0);
        end

        // ---- R lock: M0 requests during M1's data phase ----
        do_reset();
        exp_grant_q.push_back(1'b1);
        exp_grant_q.push_back(1'b0);
        run_vec(V(2'b01, 4'd0, 4'd1, 6'b100000, 9'b000000000), "lock_idle");
        run_vec(V(2'b01, 4'd0, 4'd1, 6'b100000, 9'b101000110), "lock_m1_addr");
        run_vec(V(2'b10, 4'd0, 4'd0, 6'b110010, 9'b000011110), "lock_m1_beat0");
        run_vec(V(2'b10, 4'd0, 4'd0, 6'b111010, 9'b000011110), "lock_m1_last");
        run_vec(V(2'b10, 4'd0, 4'd0, 6'b100000, 9'b000000010), "lock_bubble");
        run_vec(V(2'b10, 4'd0, 4'd0, 6'b100000, 9'b110000100), "lock_m0_addr");
        run_vec(V(2'b00, 4'd0, 4'd0, 6'b111100, 9'b000101100), "lock_m0_last");
        run_vec(V(2'b00, 4'd0, 4'd0, 6'b000000, 9'b000000000), "lock_done");

        // ---- Backpressure: RREADY_M0 toggles 1,0,1,0, ARLEN=1 ----
        do_reset();
        exp_grant_q.push_back(1'b0);
        run_vec(V(2'b10, 4'd1, 4'd0, 6'b100000, 9'b000000000), "bp_idle");
        run_vec(V(2'b10, 4'd1, 4'd0, 6'b100000, 9'b110000100), "bp_addr");
        run_vec(V(2'b00, 4'd1, 4'd0, 6'b110100, 9'b000101100), "bp_rready1");
        run_vec(V(2'b00, 4'd1, 4'd0, 6'b111000, 9'b000100100), "bp_rready0");
        run_vec(V(2'b00, 4'd1, 4'd0, 6'b111100, 9'b000101100), "bp_rready1_last");
        run_vec(V(2'b00, 4'd1, 4'd0, 6'b110000, 9'b000000000), "bp_done");

        // ---- Length error, clear, and set-wins-over-clear ----
        do_reset();
        exp_grant_q.push_back(1'b0);
        exp_grant_q.push_back(1'b0);
        run_vec(V(2'b10, 4'd3, 4'd0, 6'b100000, 9'b000000000), "le_idle");
        run_vec(V(2'b10, 4'd3, 4'd0, 6'b100000, 9'b110000100), "le_addr");
        run_vec(V(2'b00, 4'd3, 4'd0, 6'b110100, 9'b000101100), "le_beat0");
        run_vec(V(2'b00, 4'd3, 4'd0, 6'b111100, 9'b000101100), "le_early_last");
        run_vec(V(2'b00, 4'd0, 4'd0, 6'b000000, 9'b000000001), "le_sticky");
        run_vec(V(2'b00, 4'd0, 4'd0, 6'b000001, 9'b000000001), "le_clr");
        run_vec(V(2'b10, 4'd0, 4'd0, 6'b100000, 9'b000000000), "le_cleared");
        run_vec(V(2'b10, 4'd0, 4'd0, 6'b100000, 9'b110000100), "le_addr2");
        run_vec(V(2'b00, 4'd0, 4'd0, 6'b110101, 9'b000101100), "le_overrun_clr");
        run_vec(V(2'b00, 4'd0, 4'd0, 6'b111100, 9'b000101101), "le_set_wins");
        run_vec(V(2'b00, 4'd0, 4'd0, 6'b000000, 9'b000000001), "le_after");

        // ---- Reset in the middle of an M1 burst ----
        do_reset();
        exp_grant_q.push_back(1'b1);
        run_vec(V(2'b01, 4'd0, 4'd2, 6'b100000, 9'b000000000), "rst_idle");
        run_vec(V(2'b01, 4'd0, 4'd2, 6'b100000, 9'b101000110), "rst_addr");
        run_vec(V(2'b00, 4'd0, 4'd2, 6'b110010, 9'b000011110), "rst_beat0");
        ARESETn = 1'b0;
        run_vec(V(2'b01, 4'd0, 4'd2, 6'b110010, 9'b000011110), "rst_asserted");
        ARESETn = 1'b1;
        run_vec(V(2'b01, 4'd0, 4'd2, 6'b110010, 9'b000000000), "rst_outputs_low");

        // ---- Withdrawal in ADDR keeps the round-robin history ----
        do_reset();
        exp_grant_q.push_back(1'b0);
        run_vec(V(2'b10, 4'd0, 4'd0, 6'b000000, 9'b000000000), "wd_idle");
        run_vec(V(2'b10, 4'd0, 4'd0, 6'b000000, 9'b100000100), "wd_addr_wait");
        run_vec(V(2'b00, 4'd0, 4'd0, 6'b000000, 9'b000000100), "wd_withdraw");
        run_vec(V(2'b11, 4'd0, 4'd0, 6'b100000, 9'b000000000), "wd_back_idle");
        run_vec(V(2'b11, 4'd0, 4'd0, 6'b100000, 9'b110000100), "wd_tie_m0");

        chk("sb_empty", 32'(exp_grant_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
